requant_pack: RTL and testbench
===============================

Name: requant_pack

Overview:
- Consumer at the far end of the scale stage's data_valid_o/data_o stream. It accepts 32-bit signed fixed-point scaled results, one per cycle.
- Per sample: arithmetic right-shift by a runtime fraction width (optional rounding), add a zero point, saturate to int8.
- Packs PACK_N int8 lanes into one output word and buffers words in a small FIFO behind a valid/ready handshake to the writeback/SRAM port.
- Input has no backpressure. The block never stalls its input; when buffering runs out, words are dropped and flagged.

Parameters:
- OUT_W, 8, output lane width in bits (signed saturation range -2^(OUT_W-1) .. 2^(OUT_W-1)-1).
- PACK_N, 4, lanes per output word.
- FIFO_DEPTH, 4, output word FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high; clears all state.
- cfg_valid_i  in  1  load cfg_shift_i/cfg_zp_i.
- cfg_shift_i  in  5  right-shift amount, 0..31.
- cfg_zp_i  in  OUT_W  signed zero point.
- data_valid_i  in  1  sample valid.
- data_i  in  32  signed scaled sample.
- flush_i  in  1  pulse: emit partial word once the pipeline drains.
- word_valid_o  out  1  FIFO head valid.
- word_ready_i  in  1  downstream accepts head.
- word_o  out  PACK_N*OUT_W  packed lanes; lane 0 in LSBs.
- word_count_o  out  $clog2(PACK_N+1)  number of valid lanes in word_o (PACK_N for full words).
- overflow_o  out  1  sticky: a word was dropped because the FIFO was full.
- busy_o  out  1  pipeline, packer, pending flush or FIFO non-empty.

Behaviour:
- Reset values: all outputs 0; shift_r=0, zp_r=0, lane counter 0, FIFO empty, flush pending 0.
- Config:
  - cfg_valid_i with busy_o=0 updates shift_r/zp_r at that edge; the values are used by samples arriving from the next cycle on.
  - cfg_valid_i with busy_o=1 is ignored.
- Stage 1 (registered): 33-bit signed extension x of data_i; s=shift_r.
  - If s=0: y=x.
  - Otherwise y = x>>>s, or, with rounding, as defined in Optional Feature.
- Stage 2 (registered): z = y + zp_r in 34 bits, then saturated to OUT_W. 0x7FFFFFFF at s=0 gives 127; 0x80000000 gives -128.
- Packer:
  - Each stage-2 valid writes lane[cnt] and increments cnt.
  - When cnt reaches PACK_N, the word is pushed with count=PACK_N and cnt returns to 0 on the same edge; a back-to-back stream has no gap.
  - Unwritten lanes of a partial word are 0.
- Latency: a sample completing a word at input edge t gives word_valid_o=1 after edge t+3 when the FIFO was empty.
- Flush:
  - flush_i sets flush_pending.
  - When stages 1 and 2 are empty and no sample enters that cycle: if cnt>0, push the partial word with count=cnt and clear cnt. In either case clear flush_pending.
  - flush_i in the same cycle as data_valid_i: that sample is included in the flush.
  - flush_i while already pending: no extra effect.
- FIFO:
  - Push when full with no pop: word dropped, overflow_o set until reset.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop occurs when word_valid_o && word_ready_i.
  - word_o/word_count_o hold stable while word_valid_o && !word_ready_i.
- Reset mid-operation: all in-flight samples, partial lanes and FIFO words are discarded immediately (asynchronous).

Optional Feature:
- Macro REQUANT_ROUND_EN.
- Defined: round half away from zero when s>0, with h=1<<(s-1).
  - x>=0: y=(x+h)>>>s.
  - x<0: y=(x+h-1)>>>s.
- Undefined: y=x>>>s (floor); no rounding adder is synthesised.

Decomposition:
- Shared package: OUT_W/PACK_N defaults, shift width constant (5), and a saturation function, reused by later requant variants.
- One natural sub-module, requant_fifo: synchronous FIFO with count, full, empty and same-cycle push/pop when full.

Test Plan:
- Rounding: cfg shift=8, zp=0; data 4736, then -320.
  - With REQUANT_ROUND_EN: lanes 19 and -1.
  - Without it: lanes 18 and -2.
- Saturation/zero point: shift=0, zp=10; data 120, -200, 0x7FFFFFFF, 0x80000000 -> one word, lanes {127,-128,127,-128}, count 4, valid 3 cycles after the last sample.
- Streaming: 8 back-to-back samples 1..8 with shift=0, zp=0, ready=1 -> words 0x04030201 then 0x08070605, no gaps.
- Flush: samples 5, 6 then flush_i -> one word 0x00000605 with count 2; a second flush with the packer empty pushes nothing.
- Backpressure/overflow: ready=0, 20 samples (5 words) into FIFO_DEPTH=4 -> overflow_o=1; the first 4 words drain intact once ready=1.
- Config while busy ignored; async reset mid-stream clears word_valid_o, overflow_o and busy_o immediately.

Source files
------------

// File: rtl/requant_pack_pkg.sv
// requant_pack_pkg: shared constants, types and saturation helper for requant variants.
// Rev 1.0
`default_nettype none

package requant_pack_pkg;

    localparam int unsigned OUT_W_DEF  = 8;
    localparam int unsigned PACK_N_DEF = 4;
    localparam int unsigned SHIFT_W    = 5;
    localparam int unsigned DATA_W     = 32;

    typedef logic [SHIFT_W-1:0] shift_t;

    // Clamp a 34-bit signed value to the signed range of a w-bit integer.
    function automatic logic signed [33:0] sat_s34(input logic signed [33:0] v,
                                                   input int unsigned        w);
        logic signed [33:0] hi;
        logic signed [33:0] lo;
        hi = (34'sd1 <<< (w - 1)) - 34'sd1;
        lo = -(34'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/requant_pack_if.sv
// requant_pack_if: packed-word valid/ready bus towards the writeback port.
// Rev 1.0
`default_nettype none

interface requant_pack_if #(
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned PACK_N = 4
);
    localparam int unsigned CNT_W = $clog2(PACK_N + 1);

    logic                      valid;
    logic                      ready;
    logic [PACK_N*OUT_W-1:0]   data;
    logic [CNT_W-1:0]          count;

    modport master (output valid, output data, output count, input ready);
    modport slave  (input valid, input data, input count, output ready);
endinterface

`default_nettype wire

// File: rtl/requant_fifo.sv
// requant_fifo: synchronous FIFO with occupancy count; push is accepted when full if a pop happens the same cycle.
// Rev 1.0
`default_nettype none

module requant_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  wire logic                       clk_i,
    input  wire logic                       rst_i,
    input  wire logic                       push_i,
    input  wire logic [WIDTH-1:0]           data_i,
    input  wire logic                       pop_i,
    output logic      [WIDTH-1:0]           data_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic      [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++)
                mem_q[i] <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (w_pop)
                rd_q <= rd_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/requant_pack.sv
// requant_pack: shift/round, zero-point add, int saturate, lane packing and word FIFO.
// Optional macro REQUANT_ROUND_EN selects round-half-away-from-zero instead of floor. Rev 1.0
`default_nettype none

module requant_pack
    import requant_pack_pkg::*;
#(
    parameter int unsigned OUT_W      = OUT_W_DEF,
    parameter int unsigned PACK_N     = PACK_N_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  cfg_valid_i,
    input  wire shift_t                cfg_shift_i,
    input  wire logic [OUT_W-1:0]      cfg_zp_i,
    input  wire logic                  data_valid_i,
    input  wire logic [DATA_W-1:0]     data_i,
    input  wire logic                  flush_i,
    requant_pack_if.master             word_if,
    output logic                       overflow_o,
    output logic                       busy_o
);
    localparam int unsigned CNT_W  = $clog2(PACK_N + 1);
    localparam int unsigned WORD_W = PACK_N * OUT_W;

    shift_t                   shift_q;
    logic signed [OUT_W-1:0]  zp_q;
    logic                     s1_v_q;
    logic signed [32:0]       s1_y_q;
    logic                     s2_v_q;
    logic [OUT_W-1:0]         s2_lane_q;
    logic [WORD_W-1:0]        lanes_q, lanes_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pk_v_q, pk_v_d;
    logic [WORD_W-1:0]        pk_word_q, pk_word_d;
    logic [CNT_W-1:0]         pk_cnt_q, pk_cnt_d;
    logic                     flush_pend_q, flush_pend_d;
    logic                     overflow_q;

    logic signed [32:0]       w_x;
    logic signed [32:0]       y_d;
    logic signed [33:0]       w_z;
    logic [WORD_W-1:0]        w_merged;
    logic                     w_drain;
    logic                     w_pop;
    logic [CNT_W+WORD_W-1:0]  w_fifo_out;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    assign w_x = {data_i[DATA_W-1], data_i};

`ifdef REQUANT_ROUND_EN
    logic signed [32:0] w_h;
    assign w_h = 33'sd1 <<< (shift_q - 1'b1);

    always_comb begin
        y_d = w_x;
        if (shift_q != '0) begin
            if (!w_x[32])
                y_d = (w_x + w_h) >>> shift_q;
            else
                y_d = (w_x + w_h - 33'sd1) >>> shift_q;
        end
    end
`else
    assign y_d = (shift_q == '0) ? w_x : (w_x >>> shift_q);
`endif

    assign w_z = 34'(s1_y_q) + 34'(zp_q);

    // Flush completes only once nothing is left upstream of the packer.
    assign w_drain = (flush_pend_q || flush_i) && !s1_v_q && !s2_v_q && !data_valid_i;

    always_comb begin
        w_merged     = lanes_q;
        lanes_d      = lanes_q;
        cnt_d        = cnt_q;
        pk_v_d       = 1'b0;
        pk_word_d    = pk_word_q;
        pk_cnt_d     = pk_cnt_q;
        flush_pend_d = flush_pend_q || flush_i;
        if (s2_v_q) begin
            for (int i = 0; i < int'(PACK_N); i++)
                if (cnt_q == CNT_W'(i))
                    w_merged[i*OUT_W +: OUT_W] = s2_lane_q;
            if (cnt_q == CNT_W'(PACK_N - 1)) begin
                pk_v_d    = 1'b1;
                pk_word_d = w_merged;
                pk_cnt_d  = CNT_W'(PACK_N);
                cnt_d     = '0;
                lanes_d   = '0;
            end else begin
                lanes_d = w_merged;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (w_drain) begin
            flush_pend_d = 1'b0;
            if (cnt_q != '0) begin
                pk_v_d    = 1'b1;
                pk_word_d = lanes_q;
                pk_cnt_d  = cnt_q;
                cnt_d     = '0;
                lanes_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q      <= '0;
            zp_q         <= '0;
            s1_v_q       <= 1'b0;
            s1_y_q       <= '0;
            s2_v_q       <= 1'b0;
            s2_lane_q    <= '0;
            lanes_q      <= '0;
            cnt_q        <= '0;
            pk_v_q       <= 1'b0;
            pk_word_q    <= '0;
            pk_cnt_q     <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (cfg_valid_i && !busy_o) begin
                shift_q <= cfg_shift_i;
                zp_q    <= cfg_zp_i;
            end
            s1_v_q       <= data_valid_i;
            s1_y_q       <= y_d;
            s2_v_q       <= s1_v_q;
            s2_lane_q    <= OUT_W'(sat_s34(w_z, OUT_W));
            lanes_q      <= lanes_d;
            cnt_q        <= cnt_d;
            pk_v_q       <= pk_v_d;
            pk_word_q    <= pk_word_d;
            pk_cnt_q     <= pk_cnt_d;
            flush_pend_q <= flush_pend_d;
            if (pk_v_q && w_fifo_full && !w_pop)
                overflow_q <= 1'b1;
        end
    end

    requant_fifo #(
        .WIDTH (CNT_W + WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pk_v_q),
        .data_i  ({pk_cnt_q, pk_word_q}),
        .pop_i   (w_pop),
        .data_o  (w_fifo_out),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full),
        .count_o (w_fifo_count)
    );

    assign w_pop         = word_if.valid && word_if.ready;
    assign word_if.valid = !w_fifo_empty;
    assign word_if.data  = w_fifo_empty ? '0 : w_fifo_out[WORD_W-1:0];
    assign word_if.count = w_fifo_empty ? '0 : w_fifo_out[CNT_W+WORD_W-1:WORD_W];
    assign overflow_o    = overflow_q;
    assign busy_o        = s1_v_q || s2_v_q || (cnt_q != '0) || pk_v_q || flush_pend_q
                           || (w_fifo_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_requant_pack.sv
// tb_requant_pack: directed self-checking bench for requant_pack.
// Rev 1.0
`default_nettype none

module tb_requant_pack;
    import requant_pack_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    shift_t      cfg_shift = '0;
    logic [7:0]  cfg_zp = '0;
    logic        data_valid = 1'b0;
    logic [31:0] data = '0;
    logic        flush = 1'b0;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    requant_pack_if #(.OUT_W(8), .PACK_N(4)) wif ();

    requant_pack dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_shift_i  (cfg_shift),
        .cfg_zp_i     (cfg_zp),
        .data_valid_i (data_valid),
        .data_i       (data),
        .flush_i      (flush),
        .word_if      (wif.master),
        .overflow_o   (overflow),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        data_valid = 1'b1;
        data       = d;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic cfg(input int unsigned sh, input logic [7:0] zp);
        cfg_valid = 1'b1;
        cfg_shift = shift_t'(sh);
        cfg_zp    = zp;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic [2:0] c);
        int n = 0;
        while (!wif.valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, wif.valid, 1'b1);
        if (wif.valid) begin
            chk({tag, "_word"}, wif.data, w);
            chk({tag, "_count"}, wif.count, c);
            wif.ready = 1'b1;
            tick();
            wif.ready = 1'b0;
        end
    endtask

    initial begin
        wif.ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", wif.valid, 1'b0);
        chk("rst_word", wif.data, 32'h0);
        chk("rst_count", wif.count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // Rounding vs floor at shift 8
        cfg(8, 8'd0);
        send(32'd4736);
        send(32'hFFFF_FEC0);
        pulse_flush();
`ifdef REQUANT_ROUND_EN
        expect_word("round", 32'h0000_FF13, 3'd2);
`else
        expect_word("round", 32'h0000_FE12, 3'd2);
`endif

        // Saturation with zero point and exact latency
        repeat (3) tick();
        cfg(0, 8'd10);
        send(32'd120);
        send(32'hFFFF_FF38);
        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        chk("lat_t0", wif.valid, 1'b0);
        tick();
        chk("lat_t1", wif.valid, 1'b0);
        tick();
        chk("lat_t2", wif.valid, 1'b0);
        tick();
        chk("lat_t3", wif.valid, 1'b1);
        expect_word("sat", 32'h807F_807F, 3'd4);

        // Streaming
        repeat (3) tick();
        cfg(0, 8'd0);
        for (int i = 1; i <= 8; i++) send(32'(i));
        expect_word("stream0", 32'h0403_0201, 3'd4);
        expect_word("stream1", 32'h0807_0605, 3'd4);

        // Flush of a partial word, then an empty flush
        send(32'd5);
        send(32'd6);
        pulse_flush();
        expect_word("flush", 32'h0000_0605, 3'd2);
        pulse_flush();
        repeat (8) tick();
        chk("flush_empty_valid", wif.valid, 1'b0);
        chk("flush_empty_busy", busy, 1'b0);

        // Backpressure and overflow
        for (int i = 1; i <= 20; i++) send(32'(i));
        repeat (8) tick();
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_busy", busy, 1'b1);
        cfg(1, 8'd5);
        expect_word("ovf0", 32'h0403_0201, 3'd4);
        expect_word("ovf1", 32'h0807_0605, 3'd4);
        expect_word("ovf2", 32'h0C0B_0A09, 3'd4);
        expect_word("ovf3", 32'h100F_0E0D, 3'd4);
        repeat (5) tick();
        chk("ovf_drained", wif.valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Config issued while busy must not have taken effect
        for (int i = 1; i <= 4; i++) send(32'(i));
        expect_word("cfg_ignored", 32'h0403_0201, 3'd4);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 5; i++) send(32'(i));
        repeat (4) tick();
        chk("pre_rst_valid", wif.valid, 1'b1);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", wif.valid, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_word", wif.data, 32'h0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("post_rst_valid", wif.valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
